scroll_bg_renderer: RTL and testbench

SCROLL_BG_RENDERER -- requirements
Module: scroll_bg_renderer

---
 rtl/bg_render_pkg.sv | 25 ++
 rtl/scroll_bg_renderer_if.sv | 20 ++
 rtl/bg_tile_walker.sv | 78 +++++++
 rtl/scroll_bg_renderer.sv | 177 +++++++++++++++++
 tb/tb_scroll_bg_renderer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bg_render_pkg.sv
// bg_render_pkg
//   Shared definitions for the scrolling background renderer: the frame
//   sequencer state encoding and the default screen/tile geometry.
//   Optional build macro used by the renderer: COLOR_KEY_EN.
package bg_render_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAW  = 3'd3,
    S_NEXT  = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  localparam int DEF_SCREEN_TILES_X = 20;
  localparam int DEF_SCREEN_TILES_Y = 15;
  localparam int DEF_TILE_W         = 8;
  localparam int DEF_TILE_H         = 8;
  localparam int DEF_MAP_LEN        = 100;
  localparam int DEF_COLOR_DEPTH    = 9;
  localparam int DEF_TILE_CODE_W    = 3;
  localparam int DEF_COLOR_KEY      = 0;

endpackage

// File: rtl/scroll_bg_renderer_if.sv
// scroll_bg_renderer_if
//   ROM bus between the renderer and its two synchronous ROMs.
//   level_addr -> level_tile : tilemap ROM, data one cycle after address
//   tile_addr  -> tile_data  : tileset ROM, data one cycle after address
//   master = renderer, slave = ROM side.
interface scroll_bg_renderer_if #(
  parameter int TILE_CODE_W = 3,
  parameter int TILE_AW     = 9,
  parameter int COLOR_DEPTH = 9
) ();
  logic [15:0]            level_addr;
  logic [TILE_CODE_W-1:0] level_tile;
  logic [TILE_AW-1:0]     tile_addr;
  logic [COLOR_DEPTH-1:0] tile_data;

  modport master (output level_addr, output tile_addr,
                  input  level_tile, input  tile_data);
  modport slave  (input  level_addr, input  tile_addr,
                  output level_tile, output tile_data);
endinterface

// File: rtl/bg_tile_walker.sv
// bg_tile_walker
//   Walks the pixels of one tile (px fastest), forms the tileset address and
//   the screen coordinate of each pixel, and clips pixels that fall off the
//   left/right screen edge because of the fine scroll.
//   Ports: clock, resetn; en (DRAW active); tile_code, col, row, fine;
//   tile_addr (combinational), last (final pixel of tile this cycle);
//   pix_valid/pix_x/pix_y registered one cycle after tile_addr.
module bg_tile_walker #(
  parameter int SCREEN_TILES_X = 20,
  parameter int TILE_W         = 8,
  parameter int TILE_H         = 8,
  parameter int TILE_CODE_W    = 3,
  parameter int CW             = 5,
  parameter int RW             = 4,
  parameter int XW             = 8,
  parameter int YW             = 7
) (
  input  logic                                          clock,
  input  logic                                          resetn,
  input  logic                                          en,
  input  logic [TILE_CODE_W-1:0]                        tile_code,
  input  logic [CW-1:0]                                 col,
  input  logic [RW-1:0]                                 row,
  input  logic [$clog2(TILE_W)-1:0]                     fine,
  output logic [TILE_CODE_W+$clog2(TILE_W*TILE_H)-1:0]  tile_addr,
  output logic                                          last,
  output logic                                          pix_valid,
  output logic [XW-1:0]                                 pix_x,
  output logic [YW-1:0]                                 pix_y
);

  localparam int PXW      = $clog2(TILE_W);
  localparam int PYW      = $clog2(TILE_H);
  localparam int SCREEN_W = SCREEN_TILES_X * TILE_W;
  localparam int PW       = CW + PXW + 1;

  logic [PXW-1:0] px;
  logic [PYW-1:0] py;
  logic [PW-1:0]  pos;
  logic [PW-1:0]  sx;
  logic           in_bounds;

  // Power-of-two tile sizes make code*W*H + py*W + px a plain concatenation.
  assign tile_addr = {tile_code, py, px};
  assign last      = en && (px == PXW'(TILE_W - 1)) && (py == PYW'(TILE_H - 1));

  // pos is the pixel's position in the rendered strip, before the fine shift.
  assign pos       = PW'({col, px});
  assign sx        = pos - PW'(fine);
  assign in_bounds = (pos >= PW'(fine)) && (sx < PW'(SCREEN_W));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (px == PXW'(TILE_W - 1)) begin
        px <= '0;
        py <= (py == PYW'(TILE_H - 1)) ? '0 : py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      pix_valid <= en && in_bounds;
      pix_x     <= XW'(sx);
      pix_y     <= YW'({row, py});
    end
  end

endmodule

// File: rtl/scroll_bg_renderer.sv
// scroll_bg_renderer
//   Renders one frame of a horizontally scrolling tile background. Tiles are
//   fetched row-major from the tilemap ROM, then each tile's pixels are read
//   from the tileset ROM and emitted as plot/x/y/color.
//   Ports: clock, resetn (async, active-low); start, x_offset_px;
//   rom (ROM bus: level_addr/level_tile, tile_addr/tile_data);
//   x, y, color, plot; busy, done.
//   Build macro COLOR_KEY_EN: when defined, pixels equal to COLOR_KEY are
//   not plotted.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | level_addr presented to tilemap ROM
//   WAIT   | tile code arrives, latched at end of cycle
//   DRAW   | TILE_W*TILE_H pixel reads from tileset ROM
//   NEXT   | advance to next column/row
//   FLUSH  | final pixel leaves the output register
module scroll_bg_renderer
  import bg_render_pkg::*;
#(
  parameter int SCREEN_TILES_X = DEF_SCREEN_TILES_X,
  parameter int SCREEN_TILES_Y = DEF_SCREEN_TILES_Y,
  parameter int TILE_W         = DEF_TILE_W,
  parameter int TILE_H         = DEF_TILE_H,
  parameter int MAP_LEN        = DEF_MAP_LEN,
  parameter int COLOR_DEPTH    = DEF_COLOR_DEPTH,
  parameter int TILE_CODE_W    = DEF_TILE_CODE_W,
  parameter int COLOR_KEY      = DEF_COLOR_KEY
) (
  input  logic                                          clock,
  input  logic                                          resetn,
  input  logic                                          start,
  input  logic [15:0]                                   x_offset_px,
  scroll_bg_renderer_if.master                          rom,
  output logic [$clog2(SCREEN_TILES_X*TILE_W)-1:0]      x,
  output logic [$clog2(SCREEN_TILES_Y*TILE_H)-1:0]      y,
  output logic [COLOR_DEPTH-1:0]                        color,
  output logic                                          plot,
  output logic                                          busy,
  output logic                                          done
);

  localparam int XW     = $clog2(SCREEN_TILES_X * TILE_W);
  localparam int YW     = $clog2(SCREEN_TILES_Y * TILE_H);
  localparam int FINE_W = $clog2(TILE_W);
  localparam int CW     = $clog2(SCREEN_TILES_X + 2);
  localparam int RW     = $clog2(SCREEN_TILES_Y + 1);

  state_t                 state, next_state;
  logic [FINE_W-1:0]      fine_q;
  logic [15:0]            map_col0;
  logic [15:0]            map_col;
  logic [15:0]            row_base;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [TILE_CODE_W-1:0] tile_code;
  logic [15:0]            start_col;
  logic [CW-1:0]          last_col_idx;
  logic                   accept, last_col, last_row;
  logic                   walk_en, walk_last, walk_valid, key_ok;
  logic [XW-1:0]          walk_x;
  logic [YW-1:0]          walk_y;

  assign accept       = (state == S_IDLE) && start;
  assign start_col    = 16'((x_offset_px >> FINE_W) % MAP_LEN);
  // A non-zero fine scroll exposes part of one extra column on the right.
  assign last_col_idx = (fine_q == '0) ? CW'(SCREEN_TILES_X - 1) : CW'(SCREEN_TILES_X);
  assign last_col     = (col == last_col_idx);
  assign last_row     = (row == RW'(SCREEN_TILES_Y - 1));
  assign walk_en      = (state == S_DRAW);
  assign rom.level_addr = row_base + map_col;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_FETCH;
      S_FETCH: next_state = S_WAIT;
      S_WAIT:  next_state = S_DRAW;
      S_DRAW:  if (walk_last) next_state = S_NEXT;
      S_NEXT:  next_state = (last_col && last_row) ? S_FLUSH : S_FETCH;
      S_FLUSH: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fine_q    <= '0;
      map_col0  <= '0;
      map_col   <= '0;
      row_base  <= '0;
      col       <= '0;
      row       <= '0;
      tile_code <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_FLUSH);
      if (accept) begin
        fine_q   <= x_offset_px[FINE_W-1:0];
        map_col0 <= start_col;
        map_col  <= start_col;
        row_base <= '0;
        col      <= '0;
        row      <= '0;
        busy     <= 1'b1;
      end else if (state == S_FLUSH) begin
        busy <= 1'b0;
      end
      if (state == S_WAIT) tile_code <= rom.level_tile;
      if ((state == S_NEXT) && !(last_col && last_row)) begin
        if (last_col) begin
          col      <= '0;
          row      <= row + 1'b1;
          row_base <= row_base + 16'(MAP_LEN);
          map_col  <= map_col0;
        end else begin
          col     <= col + 1'b1;
          map_col <= (map_col == 16'(MAP_LEN - 1)) ? '0 : map_col + 1'b1;
        end
      end
    end
  end

  bg_tile_walker #(
    .SCREEN_TILES_X (SCREEN_TILES_X),
    .TILE_W         (TILE_W),
    .TILE_H         (TILE_H),
    .TILE_CODE_W    (TILE_CODE_W),
    .CW             (CW),
    .RW             (RW),
    .XW             (XW),
    .YW             (YW)
  ) u_walker (
    .clock     (clock),
    .resetn    (resetn),
    .en        (walk_en),
    .tile_code (tile_code),
    .col       (col),
    .row       (row),
    .fine      (fine_q),
    .tile_addr (rom.tile_addr),
    .last      (walk_last),
    .pix_valid (walk_valid),
    .pix_x     (walk_x),
    .pix_y     (walk_y)
  );

`ifdef COLOR_KEY_EN
  assign key_ok = (rom.tile_data != COLOR_DEPTH'(COLOR_KEY));
`else
  assign key_ok = 1'b1;
`endif

  // tile_data for the walker's registered coordinate is on the bus now.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plot  <= 1'b0;
      x     <= '0;
      y     <= '0;
      color <= '0;
    end else begin
      plot <= walk_valid && key_ok;
      if (walk_valid) begin
        x     <= walk_x;
        y     <= walk_y;
        color <= rom.tile_data;
      end
    end
  end

endmodule

// File: tb/tb_scroll_bg_renderer.sv
// tb_scroll_bg_renderer
//   Directed bench for scroll_bg_renderer with behavioural tilemap/tileset
//   ROMs and a pixel monitor that compares every plot against a reference
//   picture built from the ROM contents and the scroll offset.
module tb_scroll_bg_renderer;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [15:0] x_offset_px;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [8:0]  color;
  logic        plot, busy, done;

  logic [2:0]  map_rom  [0:1499];
  logic [8:0]  tile_rom [0:511];

  int n_checks;
  int n_fail;

  scroll_bg_renderer_if #(.TILE_CODE_W(3), .TILE_AW(9), .COLOR_DEPTH(9)) rom_if ();

  scroll_bg_renderer dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .x_offset_px (x_offset_px),
    .rom         (rom_if),
    .x           (x),
    .y           (y),
    .color       (color),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    rom_if.level_tile <= (rom_if.level_addr < 16'd1500) ? map_rom[rom_if.level_addr] : 3'd0;
    rom_if.tile_data  <= tile_rom[rom_if.tile_addr];
  end

  // monitor state
  bit cov       [0:19199];
  bit seen_addr [0:1499];
  int mon_en, mon_off;
  int plot_cnt, oob_cnt, dup_cnt, color_err, done_cnt, plot_after_done;
  int done_seen, saw_row5, t0_cnt;
  int addr_cnt, row0_cnt, hi_col_cnt, seq_n, seq0, seq1;
  logic [8:0] x0y0;

  function automatic logic [8:0] exp_color(input int px_x, input int px_y, input int off);
    int wx;
    int code;
    wx   = px_x + off;
    code = int'(map_rom[(px_y / 8) * 100 + (wx / 8) % 100]);
    return tile_rom[code * 64 + (px_y % 8) * 8 + wx % 8];
  endfunction

  always @(negedge clock) begin
    int idx;
    int a;
    if (mon_en != 0) begin
      if (plot) begin
        plot_cnt++;
        if (done_seen != 0) plot_after_done++;
        if (x >= 8'd160 || y >= 7'd120) oob_cnt++;
        else begin
          idx = int'(y) * 160 + int'(x);
          if (cov[idx]) dup_cnt++;
          else cov[idx] = 1'b1;
          if (color !== exp_color(int'(x), int'(y), mon_off)) color_err++;
          if (x == 8'd0 && y == 7'd0) x0y0 = color;
          if (x < 8'd8 && y < 7'd8) t0_cnt++;
          if (y == 7'd40) saw_row5 = 1;
        end
      end
      if (done) begin
        done_cnt++;
        done_seen = 1;
      end
      if (busy) begin
        a = int'(rom_if.level_addr);
        if (a < 1500 && !seen_addr[a]) begin
          seen_addr[a] = 1'b1;
          addr_cnt++;
          if (a < 100) row0_cnt++;
          if (a % 100 >= 20) hi_col_cnt++;
        end
        if (seq_n == 0) begin
          seq0 = a; seq_n = 1;
        end else if (seq_n == 1 && a != seq0) begin
          seq1 = a; seq_n = 2;
        end
      end
    end
  end

  task automatic clear_mon(input int off);
    for (int i = 0; i < 19200; i++) cov[i] = 1'b0;
    for (int i = 0; i < 1500; i++) seen_addr[i] = 1'b0;
    mon_off = off;
    plot_cnt = 0; oob_cnt = 0; dup_cnt = 0; color_err = 0; done_cnt = 0;
    plot_after_done = 0; done_seen = 0; saw_row5 = 0; t0_cnt = 0;
    addr_cnt = 0; row0_cnt = 0; hi_col_cnt = 0; seq_n = 0; seq0 = -1; seq1 = -1;
    x0y0 = '0;
  endtask

  task automatic fill_map_const(input logic [2:0] code);
    for (int i = 0; i < 1500; i++) map_rom[i] = code;
  endtask

  task automatic fill_map_var();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 100; c++)
        map_rom[r * 100 + c] = 3'(2 + (r + c) % 5);
  endtask

  task automatic pulse_start(input logic [15:0] off);
    @(negedge clock);
    x_offset_px = off;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clock);
    n_checks++; if (rom_if.level_addr !== 16'd0) begin n_fail++; $display("FAIL reset_level_addr: got %0d expected 0", rom_if.level_addr); end
    n_checks++; if (rom_if.tile_addr !== 9'd0) begin n_fail++; $display("FAIL reset_tile_addr: got %0d expected 0", rom_if.tile_addr); end
    n_checks++; if (x !== 8'd0) begin n_fail++; $display("FAIL reset_x: got %0d expected 0", x); end
    n_checks++; if (y !== 7'd0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", y); end
    n_checks++; if (color !== 9'd0) begin n_fail++; $display("FAIL reset_color: got %0d expected 0", color); end
    n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %0d expected 0", plot); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d expected 0", done); end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Offset 0 frame; a second start and an offset change mid-frame must not disturb it.
  task automatic test_frame_offset0();
    fill_map_const(3'd1);
    clear_mon(0);
    pulse_start(16'd0);
    for (int i = 0; i < 25000 && done_seen == 0; i++) begin
      @(negedge clock);
      if (i == 3000) begin start = 1'b1; x_offset_px = 16'd21; end
      if (i == 3001) start = 1'b0;
    end
    repeat (4) @(negedge clock);
    n_checks++; if (done_seen !== 1) begin n_fail++; $display("FAIL f0_done_timeout: got %0d expected 1", done_seen); end
    n_checks++; if (plot_cnt !== 19200) begin n_fail++; $display("FAIL f0_plot_count: got %0d expected 19200", plot_cnt); end
    n_checks++; if (dup_cnt !== 0) begin n_fail++; $display("FAIL f0_duplicates: got %0d expected 0", dup_cnt); end
    n_checks++; if (oob_cnt !== 0) begin n_fail++; $display("FAIL f0_out_of_range: got %0d expected 0", oob_cnt); end
    n_checks++; if (color_err !== 0) begin n_fail++; $display("FAIL f0_color: got %0d bad pixels expected 0", color_err); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL f0_done_pulses: got %0d expected 1", done_cnt); end
    n_checks++; if (plot_after_done !== 0) begin n_fail++; $display("FAIL f0_plot_after_done: got %0d expected 0", plot_after_done); end
    n_checks++; if (addr_cnt !== 300) begin n_fail++; $display("FAIL f0_fetch_count: got %0d expected 300", addr_cnt); end
    n_checks++; if (hi_col_cnt !== 0) begin n_fail++; $display("FAIL f0_extra_columns: got %0d expected 0", hi_col_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL f0_busy_end: got %0d expected 0", busy); end
  endtask

  // Offset 792 wraps column 1 to map column 0; reset lands during row 5.
  task automatic test_wrap_and_reset();
    fill_map_var();
    clear_mon(792);
    pulse_start(16'd792);
    for (int i = 0; i < 12000 && saw_row5 == 0; i++) @(negedge clock);
    n_checks++; if (saw_row5 !== 1) begin n_fail++; $display("FAIL wrap_row5_timeout: got %0d expected 1", saw_row5); end
    n_checks++; if (seq0 !== 99) begin n_fail++; $display("FAIL wrap_first_addr: got %0d expected 99", seq0); end
    n_checks++; if (seq1 !== 0) begin n_fail++; $display("FAIL wrap_second_addr: got %0d expected 0", seq1); end
    n_checks++; if (color_err !== 0) begin n_fail++; $display("FAIL wrap_color: got %0d bad pixels expected 0", color_err); end
    resetn = 1'b0;
    @(negedge clock);
    n_checks++; if (rom_if.level_addr !== 16'd0 || rom_if.tile_addr !== 9'd0 || x !== 8'd0 || y !== 7'd0
                    || color !== 9'd0 || plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got la=%0d ta=%0d x=%0d y=%0d c=%0d p=%0d b=%0d d=%0d expected all 0",
               rom_if.level_addr, rom_if.tile_addr, x, y, color, plot, busy, done);
    end
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt); end
  endtask

  // Offset 3: 21 columns per row, clipped to 160 visible pixels.
  task automatic test_offset3();
    fill_map_var();
    clear_mon(3);
    pulse_start(16'd3);
    for (int i = 0; i < 25000 && done_seen == 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    n_checks++; if (done_seen !== 1) begin n_fail++; $display("FAIL f3_done_timeout: got %0d expected 1", done_seen); end
    n_checks++; if (plot_cnt !== 19200) begin n_fail++; $display("FAIL f3_plot_count: got %0d expected 19200", plot_cnt); end
    n_checks++; if (dup_cnt !== 0) begin n_fail++; $display("FAIL f3_duplicates: got %0d expected 0", dup_cnt); end
    n_checks++; if (oob_cnt !== 0) begin n_fail++; $display("FAIL f3_out_of_range: got %0d expected 0", oob_cnt); end
    n_checks++; if (color_err !== 0) begin n_fail++; $display("FAIL f3_color: got %0d bad pixels expected 0", color_err); end
    n_checks++; if (x0y0 !== 9'd131) begin n_fail++; $display("FAIL f3_x0_pixel: got %0d expected 131", x0y0); end
    n_checks++; if (row0_cnt !== 21) begin n_fail++; $display("FAIL f3_row0_fetches: got %0d expected 21", row0_cnt); end
    n_checks++; if (addr_cnt !== 315) begin n_fail++; $display("FAIL f3_fetch_count: got %0d expected 315", addr_cnt); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL f3_done_pulses: got %0d expected 1", done_cnt); end
    n_checks++; if (plot_after_done !== 0) begin n_fail++; $display("FAIL f3_plot_after_done: got %0d expected 0", plot_after_done); end
  endtask

  // Tile 7 has value 0 in pixel column 0; only the first tile is inspected.
  task automatic test_color_key();
    int exp_t0;
`ifdef COLOR_KEY_EN
    exp_t0 = 56;
`else
    exp_t0 = 64;
`endif
    fill_map_const(3'd7);
    clear_mon(0);
    pulse_start(16'd0);
    repeat (100) @(negedge clock);
    n_checks++; if (t0_cnt !== exp_t0) begin n_fail++; $display("FAIL key_tile0_plots: got %0d expected %0d", t0_cnt, exp_t0); end
    n_checks++; if (color_err !== 0) begin n_fail++; $display("FAIL key_color: got %0d bad pixels expected 0", color_err); end
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mon_en = 0;
    start = 1'b0;
    x_offset_px = 16'd0;
    resetn = 1'b0;
    for (int t = 0; t < 8; t++)
      for (int p = 0; p < 64; p++) begin
        if (t == 1)      tile_rom[t * 64 + p] = 9'h1FF;
        else if (t == 7) tile_rom[t * 64 + p] = (p % 8 == 0) ? 9'h000 : 9'h0AA;
        else             tile_rom[t * 64 + p] = 9'(t * 64 + p);
      end
    fill_map_const(3'd1);
    clear_mon(0);

    test_reset();
    mon_en = 1;
    test_frame_offset0();
    test_wrap_and_reset();
    test_offset3();
    test_color_key();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
